mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: instruction fetch (port I, read-only) and load/store (port D, read/write).
- Sits between the multi-cycle control/datapath and the memory. It drives the memory's Address, WE and WD and captures its combinational RD.
- Uses round-robin arbitration, a registered access phase, optional wait states and a one-cycle acknowledge per transaction.

Parameters:
- ADDR_W, 32, address width of requester and memory address buses.
- DATA_W, 32, data width.
- WAIT_CYCLES, 0, extra cycles the memory address/data are held before RD is captured (0..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid this cycle.
- i_rdata  out  DATA_W  fetched word; holds until next fetch ack.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  load result; holds until next load ack.
- d_err  out  1  valid with d_ack: misaligned access (d_addr[1:0] != 0); no memory access was performed.
- mem_addr  out  ADDR_W  to memory Address.
- mem_we  out  1  to memory WE.
- mem_wd  out  DATA_W  to memory WD.
- mem_rd  in  DATA_W  from memory RD (combinational).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state = IDLE, wait counter 0, last_owner = D (so I wins the first tie).
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Sample i_req/d_req.
  - Only one asserted: grant it.
  - Both asserted: grant the port that is not last_owner.
  - On grant, register owner, mem_addr, mem_we (= d_we if D, 0 if I) and mem_wd (= d_wdata for D stores, else 0). Load the wait counter with WAIT_CYCLES and go to ACCESS.
  - D granted with misaligned address: no access; register err and go directly to RESP, with mem_we staying 0.
  - No request: stay in IDLE; mem_we = 0.
- ACCESS:
  - mem_addr/mem_we/mem_wd are driven from registers and held stable.
  - Counter != 0: decrement and stay.
  - Counter == 0: capture mem_rd into the owner's rdata register (I: i_rdata; D: d_rdata only when !mem_we). Clear mem_we at the same edge and go to RESP.
  - With WAIT_CYCLES = 0, mem_we is high for exactly one cycle, so the memory writes once.
- RESP: pulse the owner's ack (plus d_err if applicable), set last_owner = owner, go to IDLE.
- Latency from request sampled in IDLE to ack: 2 + WAIT_CYCLES cycles. A misaligned D request acks in 1 cycle.
- Back-to-back: a requester may present a new request in the cycle after its ack. With both requesters continuously requesting, grants strictly alternate I, D, I, D.
- No request is ever lost. Requests arriving while busy are served from IDLE per round-robin.
- Request dropped before its ack: protocol violation, not required to be handled. The transaction completes once started.
- Reset mid-transaction: the transaction is abandoned immediately and mem_we goes to 0 asynchronously. No ack is issued and rdata registers clear.
- The arbiter does not translate addresses; the memory handles region decoding.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  - owner constants: OWN_I = 1'b0, OWN_D = 1'b1.
- One natural sub-module, rr_arbiter2: a 2-input round-robin pick with a last_owner input, giving a grant vector and owner index. Purely combinational; last_owner is stored in mem_arbiter.

Test Plan:
- Reset then i_req=1, i_addr=0x400, mem_rd model returns 0x20020005 → i_ack pulses exactly 2 cycles after sampling; i_rdata = 0x20020005; mem_we stays 0 throughout.
- d_req=1, d_we=1, d_addr=0x50, d_wdata=0xDEADBEEF, followed by a load from 0x50 → mem_we high exactly 1 cycle with mem_addr=0x50; the later load gives d_rdata = 0xDEADBEEF with d_err = 0.
- i_req and d_req held high together for 8 transactions → ack order I, D, I, D, …; never two acks in one cycle; busy low only for the single IDLE cycle between transactions.
- d_req with d_addr=0x52 → d_ack 1 cycle after sampling with d_err=1; mem_we never asserted; memory contents unchanged.
- WAIT_CYCLES=3, fetch at 0x404 → i_ack 5 cycles after sampling; mem_addr stable at 0x404 for all 4 ACCESS cycles.
- Store in ACCESS, then rst_n deasserted asynchronously mid-cycle → mem_we falls immediately; no d_ack; after release the FSM is in IDLE and serves I first on a tie.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner IDs and
// the alignment helper used when granting the load/store port.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int unsigned WAIT_W = 4;

    // Word accesses only; any nonzero low byte-offset bit is a misaligned request.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between fetch (I) and load/store (D); the previous
// winner is supplied by the caller, which owns that state.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  logic       last_owner,
    output logic [1:0] grant,
    output logic       owner,
    output logic       valid
);

    always_comb begin
        grant = 2'b00;
        owner = OWN_I;
        valid = req_i | req_d;

        // On a tie the port that did not win last time goes next.
        if (req_i && req_d) begin
            owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            owner = OWN_D;
        end else begin
            owner = OWN_I;
        end

        grant[0] = valid && (owner == OWN_I);
        grant[1] = valid && (owner == OWN_D);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port unified memory between instruction fetch and
// load/store using round-robin grants, optional wait states and one-cycle acks.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,

    output logic              busy
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    state_t            state;
    logic              owner;
    logic              last_owner;
    logic [WAIT_W-1:0] wait_cnt;

    logic [1:0]        arb_grant;
    logic              arb_owner;
    logic              arb_valid;

    rr_arbiter2 u_rr (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_owner (last_owner),
        .grant      (arb_grant),
        .owner      (arb_owner),
        .valid      (arb_valid)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_owner <= OWN_D;
            wait_cnt   <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wd     <= '0;
            i_ack      <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;

            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (arb_valid) begin
                        owner <= arb_owner;
                        // A misaligned load/store never touches memory; it is
                        // answered with an error ack on the next cycle.
                        if (arb_grant[1] && is_misaligned(d_addr[1:0])) begin
                            d_ack <= 1'b1;
                            d_err <= 1'b1;
                            state <= RESP;
                        end else begin
                            mem_addr <= arb_grant[1] ? d_addr : i_addr;
                            mem_we   <= arb_grant[1] & d_we;
                            mem_wd   <= (arb_grant[1] && d_we) ? d_wdata : '0;
                            wait_cnt <= WAIT_LOAD;
                            state    <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        if (owner == OWN_I) begin
                            i_rdata <= mem_rd;
                            i_ack   <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                d_rdata <= mem_rd;
                            end
                            d_ack <= 1'b1;
                        end
                        mem_we <= 1'b0;
                        state  <= RESP;
                    end
                end

                RESP: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end

                default: begin
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
